element_delay_accumulator: RTL

ELEMENT_DELAY_ACCUMULATOR -- requirements
Module: element_delay_accumulator

---
 rtl/element_delay_accumulator.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/element_delay_accumulator.sv
// element_delay_accumulator
//
// Produces the per-element delays of one array sweep. Element 0 takes
// init_delay; each following element adds an increment term fetched from
// an external term calculator, with the sum clamped to the signed range.
//
// Ports
//   clk          : single clock, rising edge
//   rst          : synchronous, active-low reset
//   start        : begins a sweep (only honoured in IDLE)
//   init_delay   : signed delay of element 0
//   term_in      : signed increment term, qualified by term_ready
//   term_ready   : term calculator result valid (only looked at in WAIT)
//   term_initiate: one-cycle request to the term calculator
//   term_ack     : one-cycle acknowledge of the consumed term
//   delay_out    : current element delay
//   delay_idx    : element index of delay_out
//   delay_valid  : delay_out/delay_idx valid
//   delay_accept : downstream takes delay_out
//   busy         : sweep in progress (any state but IDLE)
//   done         : one-cycle sweep completion
//   sat_flag     : sticky clamp indicator, cleared by start or reset
//   state_dbg    : current FSM state encoding
//
// Handshake: a delay transfers on a rising edge where delay_valid and
// delay_accept are both 1. While delay_valid is 1 and delay_accept is 0,
// delay_out and delay_idx are held stable and delay_valid stays high.
module element_delay_accumulator #(
    parameter int DW_INTEGER   = 18,
    parameter int DW_FRACTION  = 6,
    parameter int NUM_ELEMENTS = 32,
    parameter int IDX_DW       = 5
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [DW_INTEGER+DW_FRACTION:0]       init_delay,
    input  logic [DW_INTEGER+DW_FRACTION:0]       term_in,
    input  logic                                  term_ready,
    output logic                                  term_initiate,
    output logic                                  term_ack,
    output logic [DW_INTEGER+DW_FRACTION:0]       delay_out,
    output logic [IDX_DW-1:0]                     delay_idx,
    output logic                                  delay_valid,
    input  logic                                  delay_accept,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  sat_flag,
    output logic [2:0]                            state_dbg
);

    localparam int W = DW_INTEGER + DW_FRACTION + 1;

    localparam logic [W-1:0]      SAT_MAX  = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]      SAT_MIN  = {1'b1, {(W-1){1'b0}}};
    localparam logic [IDX_DW-1:0] IDX_ONE  = IDX_DW'(1);
    localparam logic [IDX_DW-1:0] IDX_LAST = IDX_DW'(NUM_ELEMENTS - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EMIT = 3'd1,
        REQ  = 3'd2,
        WAIT = 3'd3,
        ACK  = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [W-1:0]      acc_q;
    logic [IDX_DW-1:0] idx_q;
    logic              sat_q;

    // One guard bit: overflow shows up as the two top bits of the sum
    // disagreeing; the top bit then tells which rail to clamp to.
    logic [W:0]   sum_full;
    logic         sum_ovf;
    logic [W-1:0] sum_sat;

    always_comb begin
        sum_full = {acc_q[W-1], acc_q} + {term_in[W-1], term_in};
        sum_ovf  = sum_full[W] ^ sum_full[W-1];
        sum_sat  = sum_full[W-1:0];
        if (sum_ovf) begin
            sum_sat = sum_full[W] ? SAT_MIN : SAT_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                acc_q <= init_delay;
                idx_q <= '0;
                sat_q <= 1'b0;
            end
            if (state_q == WAIT && term_ready) begin
                acc_q <= sum_sat;
                idx_q <= idx_q + IDX_ONE;
                if (sum_ovf) begin
                    sat_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = EMIT;
            EMIT: begin
                if (delay_accept) begin
                    state_d = (idx_q == IDX_LAST) ? DONE : REQ;
                end
            end
            REQ:  state_d = WAIT;
            WAIT: if (term_ready) state_d = ACK;
            ACK:  state_d = EMIT;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // All outputs are decoded from registered state, so reset (IDLE,
    // cleared accumulator) drives every output to 0 directly.
    always_comb begin
        delay_valid   = (state_q == EMIT);
        term_initiate = (state_q == REQ);
        term_ack      = (state_q == ACK);
        done          = (state_q == DONE);
        busy          = (state_q != IDLE);
        delay_out     = acc_q;
        delay_idx     = idx_q;
        sat_flag      = sat_q;
        state_dbg     = state_q;
    end

endmodule
